// File: rtl/elevator_pkg.sv
// Shared lift floor-interface types: state encoding, floor vector helpers and
// the one-hot check used by the call scheduler and the car controller.
package elevator_pkg;

  localparam int unsigned N_FLOORS_DEF = 4;
  localparam int unsigned MAX_FLOORS   = 64;

  typedef logic [MAX_FLOORS-1:0] floor_vec_t;

  localparam floor_vec_t FLOOR0 = floor_vec_t'(1);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DOOR
  } state_t;

  // Vectors are zero-extended to MAX_FLOORS so one helper serves every build width.
  function automatic floor_vec_t lowest_above(input floor_vec_t pend, input floor_vec_t cur);
    floor_vec_t res;
    logic       seen;
    res  = '0;
    seen = 1'b0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      if (seen && pend[i] && (res == '0)) res[i] = 1'b1;
      if (cur[i]) seen = 1'b1;
    end
    return res;
  endfunction

  function automatic floor_vec_t highest_below(input floor_vec_t pend, input floor_vec_t cur);
    floor_vec_t res;
    logic       seen;
    res  = '0;
    seen = 1'b0;
    for (int unsigned k = 0; k < MAX_FLOORS; k++) begin
      if (seen && pend[MAX_FLOORS-1-k] && (res == '0)) res[MAX_FLOORS-1-k] = 1'b1;
      if (cur[MAX_FLOORS-1-k]) seen = 1'b1;
    end
    return res;
  endfunction

  function automatic logic is_onehot(input floor_vec_t v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      if (v[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/floor_pick.sv
// Combinational priority selector: nearest pending floor above and below the
// car, plus flags for calls ahead/behind and a call at the current floor.
module floor_pick
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS = N_FLOORS_DEF
) (
  input  logic [N_FLOORS-1:0] i_pending,
  input  logic [N_FLOORS-1:0] i_cur_floor,
  output logic [N_FLOORS-1:0] o_next_above,
  output logic [N_FLOORS-1:0] o_next_below,
  output logic                o_any_above,
  output logic                o_any_below,
  output logic                o_at_call
);

  assign o_next_above = N_FLOORS'(lowest_above(floor_vec_t'(i_pending), floor_vec_t'(i_cur_floor)));
  assign o_next_below = N_FLOORS'(highest_below(floor_vec_t'(i_pending), floor_vec_t'(i_cur_floor)));
  assign o_any_above  = |o_next_above;
  assign o_any_below  = |o_next_below;
  assign o_at_call    = |(i_pending & i_cur_floor);

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches floor calls, drives the registered one-hot
// target floor into the car and times the door at each stop.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS    = N_FLOORS_DEF,
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic [N_FLOORS-1:0] cur_floor,
  output logic [N_FLOORS-1:0] target_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up,
  output logic                door_open,
  output logic                busy,
  output logic                err
);

  localparam int unsigned       CNT_W    = $clog2(DOOR_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

  state_t              r_state;
  logic [N_FLOORS-1:0] r_pending;
  logic [N_FLOORS-1:0] r_target;
  logic                r_dir_up;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_nxt;
  logic [N_FLOORS-1:0] w_pending_nxt;
  logic [N_FLOORS-1:0] w_target_nxt;
  logic                w_dir_nxt;
  logic                w_err_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [N_FLOORS-1:0] w_clr;
  logic                w_cur_valid;
  logic                w_same_floor_press;

  logic [N_FLOORS-1:0] w_next_above;
  logic [N_FLOORS-1:0] w_next_below;
  logic                w_any_above;
  logic                w_any_below;
  logic                w_at_call;

  floor_pick #(
    .N_FLOORS(N_FLOORS)
  ) u_floor_pick (
    .i_pending   (r_pending),
    .i_cur_floor (cur_floor),
    .o_next_above(w_next_above),
    .o_next_below(w_next_below),
    .o_any_above (w_any_above),
    .o_any_below (w_any_below),
    .o_at_call   (w_at_call)
  );

  assign w_cur_valid        = is_onehot(floor_vec_t'(cur_floor));
  assign w_same_floor_press = |(call_btn & cur_floor);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_target  <= N_FLOORS'(FLOOR0);
      r_dir_up  <= 1'b1;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_target  <= w_target_nxt;
      r_dir_up  <= w_dir_nxt;
      r_err     <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_dir_nxt    = r_dir_up;
    w_err_nxt    = r_err;
    w_cnt_nxt    = r_cnt;
    w_clr        = '0;

    if (!w_cur_valid) begin
      // Position unknown: freeze the FSM, keep accepting calls.
      w_err_nxt = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_at_call) begin
            w_state_nxt = DOOR;
          end else if (w_any_above) begin
            w_state_nxt = UP;
            w_dir_nxt   = 1'b1;
          end else if (w_any_below) begin
            w_state_nxt = DOWN;
            w_dir_nxt   = 1'b0;
          end
        end
        UP: begin
          if (w_at_call)         w_state_nxt = DOOR;
          else if (!w_any_above) w_state_nxt = IDLE;
        end
        DOWN: begin
          if (w_at_call)         w_state_nxt = DOOR;
          else if (!w_any_below) w_state_nxt = IDLE;
        end
        DOOR: begin
          if (w_same_floor_press) begin
            w_cnt_nxt = CNT_LOAD;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (r_dir_up ? w_any_above : w_any_below) begin
            w_state_nxt = r_dir_up ? UP : DOWN;
          end else if (r_dir_up ? w_any_below : w_any_above) begin
            w_state_nxt = r_dir_up ? DOWN : UP;
            w_dir_nxt   = ~r_dir_up;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase

      if ((w_state_nxt == DOOR) && (r_state != DOOR)) w_cnt_nxt = CNT_LOAD;
      if ((w_state_nxt == DOOR) || (r_state == DOOR)) w_clr = cur_floor;

      // Target follows the state being entered, so it lands one clock after the cause.
      case (w_state_nxt)
        UP:      w_target_nxt = w_next_above;
        DOWN:    w_target_nxt = w_next_below;
        default: w_target_nxt = cur_floor;
      endcase
    end

    w_pending_nxt = (r_pending | call_btn) & ~w_clr;
  end

  assign target_floor = r_target;
  assign pending      = r_pending;
  assign dir_up       = r_dir_up;
  assign door_open    = (r_state == DOOR);
  assign busy         = (r_state != IDLE) || (|r_pending);
  assign err          = r_err;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: vector table through a
// scoreboard queue, plus hand-written door-extension and fault sequences.
module tb_elevator_call_scheduler;

  localparam int unsigned NF = 4;

  typedef struct packed {
    logic          rst;
    logic [NF-1:0] btn;
    logic [NF-1:0] cur;
    logic [NF-1:0] tgt;
    logic [NF-1:0] pend;
    logic          dir;
    logic          door;
    logic          busy;
    logic          err;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [NF-1:0] call_btn;
  logic [NF-1:0] cur_floor;
  logic [NF-1:0] target_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          door_open;
  logic          busy;
  logic          err;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t mv;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   door_cycles;

  elevator_call_scheduler #(
    .N_FLOORS   (NF),
    .DOOR_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .call_btn    (call_btn),
    .cur_floor   (cur_floor),
    .target_floor(target_floor),
    .pending     (pending),
    .dir_up      (dir_up),
    .door_open   (door_open),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkv(input string name, input logic [NF-1:0] act, input logic [NF-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [NF-1:0] b, input logic [NF-1:0] c,
                              input logic [NF-1:0] t, input logic [NF-1:0] p,
                              input logic d, input logic o, input logic bz, input logic e);
    vec_t v;
    v.rst = r; v.btn = b; v.cur = c; v.tgt = t; v.pend = p;
    v.dir = d; v.door = o; v.busy = bz; v.err = e;
    return v;
  endfunction

  task automatic add(input logic r, input logic [NF-1:0] b, input logic [NF-1:0] c,
                     input logic [NF-1:0] t, input logic [NF-1:0] p,
                     input logic d, input logic o, input logic bz, input logic e);
    vecs.push_back(mk(r, b, c, t, p, d, o, bz, e));
  endtask

  task automatic addn(input int n, input logic [NF-1:0] c, input logic [NF-1:0] t,
                      input logic [NF-1:0] p, input logic d, input logic o, input logic bz);
    for (int i = 0; i < n; i++) add(1'b0, 4'b0000, c, t, p, d, o, bz, 1'b0);
  endtask

  task automatic drive(input logic r, input logic [NF-1:0] b, input logic [NF-1:0] c);
    @(negedge clk);
    rst       = r;
    call_btn  = b;
    cur_floor = c;
  endtask

  // Expected outputs describe the state just after the edge that samples these inputs.
  task automatic step(input vec_t v);
    drive(v.rst, v.btn, v.cur);
    exp_q.push_back(v);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mv = exp_q.pop_front();
      chkv("target_floor", target_floor, mv.tgt);
      chkv("pending",      pending,      mv.pend);
      chkb("dir_up",       dir_up,       mv.dir);
      chkb("door_open",    door_open,    mv.door);
      chkb("busy",         busy,         mv.busy);
      chkb("err",          err,          mv.err);
    end
  end

  initial begin
    rst       = 1'b1;
    call_btn  = '0;
    cur_floor = 4'b0001;

    // Reset with calls pressed: nothing may latch.
    add(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0);
    add(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0);

    // Single call to floor 2.
    add(0, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0001, 4'b0100, 4'b0100, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0010, 4'b0100, 4'b0100, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1, 1, 1, 0);
    addn(7, 4'b0100, 4'b0100, 4'b0000, 1, 1, 1);
    addn(2, 4'b0100, 4'b0100, 4'b0000, 1, 0, 0);

    // Intermediate stop at floor 2 on the way to floor 3.
    add(1, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b1000, 4'b0001, 4'b0001, 4'b1000, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0001, 4'b1000, 4'b1000, 1, 0, 1, 0);
    add(0, 4'b0100, 4'b0010, 4'b1000, 4'b1100, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0010, 4'b0100, 4'b1100, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 1, 1, 1, 0);
    addn(7, 4'b0100, 4'b0100, 4'b1000, 1, 1, 1);
    add(0, 4'b0000, 4'b0100, 4'b1000, 4'b1000, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 1, 1, 1, 0);
    addn(7, 4'b1000, 4'b1000, 4'b0000, 1, 1, 1);
    add(0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 1, 0, 0, 0);

    // SCAN: continue up to floor 3, then reverse down to floor 0.
    add(1, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0001, 4'b0100, 4'b0100, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1, 1, 1, 0);
    add(0, 4'b1001, 4'b0100, 4'b0100, 4'b1001, 1, 1, 1, 0);
    addn(6, 4'b0100, 4'b0100, 4'b1001, 1, 1, 1);
    add(0, 4'b0000, 4'b0100, 4'b1000, 4'b1001, 1, 0, 1, 0);
    add(0, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 1, 1, 1, 0);
    addn(7, 4'b1000, 4'b1000, 4'b0001, 1, 1, 1);
    add(0, 4'b0000, 4'b1000, 4'b0001, 4'b0001, 0, 0, 1, 0);
    add(0, 4'b0000, 4'b0100, 4'b0001, 4'b0001, 0, 0, 1, 0);
    add(0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 1, 1, 0);
    addn(7, 4'b0001, 4'b0001, 4'b0000, 0, 1, 1);
    add(0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Same-floor press during door cycle 5 re-opens the door for a full period.
    step(mk(1, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0));
    step(mk(0, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 1, 0, 1, 0));
    step(mk(0, 4'b0000, 4'b0001, 4'b0010, 4'b0010, 1, 0, 1, 0));
    @(posedge clk);
    #2;
    door_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, (door_cycles == 5) ? 4'b0010 : 4'b0000, 4'b0010);
      @(posedge clk);
      #1;
      if (door_open) door_cycles++;
      else if (door_cycles != 0) break;
    end
    chki("door_extended_cycles", door_cycles, 13);
    chkv("pending_after_same_floor_press", pending, 4'b0000);
    chkb("busy_after_extended_door", busy, 1'b0);
    chkv("target_after_extended_door", target_floor, 4'b0010);

    // Non-one-hot position: sticky err, target holds, calls still latch.
    step(mk(0, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 1, 0, 0, 1));
    step(mk(0, 4'b1000, 4'b0011, 4'b0010, 4'b1000, 1, 0, 1, 1));
    step(mk(0, 4'b0000, 4'b0010, 4'b1000, 4'b1000, 1, 0, 1, 1));
    step(mk(0, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1, 0, 1, 1));
    step(mk(1, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0));

    repeat (3) @(posedge clk);
    #2;
    chki("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
